// File: rtl/core_sched.sv
// Staggered per-core reset release with a round-robin result collector.
// One registered output slot; cores ack'd with a single-cycle pulse.
module core_sched #(
  parameter int N_CORES = 21,
  parameter int STAGGER = 22,
  parameter int DW      = 28
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  output logic [N_CORES-1:0]      core_rst,
  input  logic [N_CORES-1:0]      core_valid,
  input  logic [N_CORES*DW-1:0]   core_data,
  output logic [N_CORES-1:0]      core_ack,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DW-1:0]           out_data,
  output logic [4:0]              out_core,
  output logic                    all_started
);

  localparam int PW = (N_CORES > 1) ? $clog2(N_CORES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STAG,
    S_RUN
  } state_t;

  state_t          state;
  logic [PW-1:0]   slot;
  logic [PW-1:0]   slot_nx;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   win;
  logic [PW-1:0]   ptr_nx;
  logic [7:0]      cnt;
  logic [N_CORES-1:0] elig;
  logic [DW-1:0]   data_arr [N_CORES];
  logic [DW-1:0]   win_data;
  logic            found;
  logic            load;

  for (genvar i = 0; i < N_CORES; i++) begin : g_unpack
    assign data_arr[i] = core_data[i*DW +: DW];
  end

  // a core ack'd last cycle has not yet dropped its stale valid
  assign elig = core_valid & ~core_rst & ~core_ack;

  always_comb begin
    int j;
    logic [PW-1:0] idx;
    found    = 1'b0;
    win      = '0;
    win_data = '0;
    j        = 0;
    idx      = '0;
    for (int k = 0; k < N_CORES; k++) begin
      j = int'(ptr) + k;
      if (j >= N_CORES) j = j - N_CORES;
      idx = PW'(j);
      if (!found && elig[idx]) begin
        found    = 1'b1;
        win      = idx;
        win_data = data_arr[idx];
      end
    end
  end

  assign load    = found && (!out_valid || out_ready);
  assign slot_nx = slot + PW'(1);
  assign ptr_nx  = (int'(win) == N_CORES - 1) ? '0 : win + PW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      core_rst    <= '1;
      core_ack    <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_core    <= '0;
      ptr         <= '0;
      cnt         <= '0;
      slot        <= '0;
      all_started <= 1'b0;
    end else if (abort) begin
      state       <= S_IDLE;
      core_rst    <= '1;
      core_ack    <= '0;
      out_valid   <= 1'b0;
      cnt         <= '0;
      slot        <= '0;
      all_started <= 1'b0;
    end else begin
      core_ack <= '0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state       <= S_STAG;
            slot        <= '0;
            cnt         <= '0;
            core_rst[0] <= 1'b0;
          end
        end
        S_STAG: begin
          if (cnt == 8'(STAGGER - 1)) begin
            cnt <= '0;
            if (int'(slot) == N_CORES - 1) begin
              state       <= S_RUN;
              all_started <= 1'b1;
            end else begin
              slot              <= slot_nx;
              core_rst[slot_nx] <= 1'b0;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_RUN: ;
        default: state <= S_IDLE;
      endcase
      if (load) begin
        out_valid     <= 1'b1;
        out_data      <= win_data;
        out_core      <= 5'(win);
        core_ack[win] <= 1'b1;
        ptr           <= ptr_nx;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_core_sched.sv
// Directed bench for core_sched: stagger timing, arbitration,
// back-pressure, wrap, abort and async reset.
module tb_core_sched;

  localparam int N  = 21;
  localparam int ST = 22;
  localparam int DW = 28;
  localparam logic [N-1:0] ALL = '1;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            abort;
  logic [N-1:0]    core_rst;
  logic [N-1:0]    core_valid;
  logic [N*DW-1:0] core_data;
  logic [N-1:0]    core_ack;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic [4:0]      out_core;
  logic            all_started;

  int n_checks = 0;
  int n_errors = 0;
  int cyc;
  logic [N-1:0] m;

  core_sched #(
    .N_CORES(N),
    .STAGGER(ST),
    .DW     (DW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .core_rst   (core_rst),
    .core_valid (core_valid),
    .core_data  (core_data),
    .core_ack   (core_ack),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_core   (out_core),
    .all_started(all_started)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] dval(input int i);
    return DW'(32'h0F5C3000 + i * 32'h00010203);
  endfunction

  task automatic grant(input string tag, input int c);
    chk({tag, "_vld"}, out_valid, 1);
    chk({tag, "_core"}, out_core, c);
    chk({tag, "_ack"}, core_ack, 64'(1) << c);
    chk({tag, "_data"}, out_data, dval(c));
  endtask

  initial begin
    rst        = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    core_valid = '0;
    out_ready  = 1'b1;
    for (int i = 0; i < N; i++) core_data[i*DW +: DW] = dval(i);
    repeat (3) tick();
    chk("rst_core_rst", core_rst, ALL);
    chk("rst_ack", core_ack, 0);
    chk("rst_vld", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_core", out_core, 0);
    chk("rst_all", all_started, 0);
    rst = 1'b1;
    tick();

    // stagger timing
    start = 1'b1;
    cyc   = 0;
    tick();
    start = 1'b0;
    cyc   = 1;
    chk("c0_rel", core_rst, ALL ^ N'(1));
    while (cyc < 463) begin
      tick();
      cyc++;
      if (cyc == 22)  chk("c1_hold", core_rst[1], 1);
      if (cyc == 23)  chk("c1_rel", core_rst[1], 0);
      if (cyc == 440) chk("c20_hold", core_rst[20], 1);
      if (cyc == 441) chk("c20_rel", core_rst, 0);
      if (cyc == 462) chk("run_pre", all_started, 0);
      if (cyc == 463) chk("run_on", all_started, 1);
    end

    // round robin, ptr starts at 0
    core_valid = N'((1 << 3) | (1 << 7) | (1 << 15));
    tick(); grant("rr3", 3);  core_valid[3] = 1'b0;
    tick(); grant("rr7", 7);  core_valid[7] = 1'b0;
    tick(); grant("rr15", 15); core_valid[15] = 1'b0;
    tick();
    chk("rr_drain_vld", out_valid, 0);
    chk("rr_drain_ack", core_ack, 0);
    // ptr should now be 16
    core_valid = N'((1 << 0) | (1 << 15) | (1 << 16));
    tick(); grant("p16", 16); core_valid[16] = 1'b0;
    tick(); grant("p0", 0);   core_valid[0] = 1'b0;
    tick(); grant("p15", 15); core_valid[15] = 1'b0;
    tick();
    chk("p_drain_vld", out_valid, 0);

    // back-pressure
    core_data[2*DW +: DW] = 28'h8000001;
    out_ready     = 1'b0;
    core_valid[2] = 1'b1;
    tick();
    chk("bp_ld_ack", core_ack, 64'h4);
    chk("bp_ld_data", out_data, 28'h8000001);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_ack", core_ack, 0);
      chk("bp_hold_data", out_data, 28'h8000001);
      chk("bp_hold_vld", out_valid, 1);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_rel_ack", core_ack, 64'h4);
    chk("bp_rel_core", out_core, 2);
    core_valid[2] = 1'b0;
    core_data[2*DW +: DW] = dval(2);
    tick();
    chk("bp_fall_vld", out_valid, 0);
    chk("bp_fall_ack", core_ack, 0);

    // wrap from 20 to 0
    core_valid[19] = 1'b1;
    tick(); grant("w19", 19); core_valid[19] = 1'b0;
    tick();
    core_valid = N'((1 << 20) | 1);
    tick(); grant("w20", 20); core_valid[20] = 1'b0;
    tick(); grant("w0", 0);   core_valid[0] = 1'b0;
    tick();
    chk("w_drain_vld", out_valid, 0);

    // abort from RUN, then abort mid-stagger with output held
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_run_rst", core_rst, ALL);
    chk("ab_run_all", all_started, 0);
    core_valid[0] = 1'b1;
    out_ready     = 1'b0;
    start = 1'b1;
    cyc   = 0;
    tick();
    start = 1'b0;
    cyc   = 1;
    while (cyc < 112) begin
      tick();
      cyc++;
      if (cyc == 2) chk("ab_grant", core_ack, 1);
    end
    m = ALL << 6;
    chk("ab_slot5", core_rst, m);
    chk("ab_slot5_vld", out_valid, 1);
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    chk("ab_rst", core_rst, ALL);
    chk("ab_vld", out_valid, 0);
    chk("ab_ack", core_ack, 0);
    tick();
    chk("ab_idle", core_rst, ALL);
    core_valid = '0;
    out_ready  = 1'b1;

    // restart, with a stray start that must be ignored
    start = 1'b1;
    cyc   = 0;
    tick();
    start = 1'b0;
    cyc   = 1;
    chk("rs_c0", core_rst, ALL ^ N'(1));
    while (cyc < 23) begin
      tick();
      cyc++;
      if (cyc == 10) start = 1'b1;
      if (cyc == 11) start = 1'b0;
      if (cyc == 22) chk("rs_c1_hold", core_rst, ALL ^ N'(1));
      if (cyc == 23) chk("rs_c1_rel", core_rst, ALL ^ N'(3));
    end

    // async reset mid-transfer
    core_valid[0] = 1'b1;
    out_ready     = 1'b0;
    tick();
    chk("ar_pre_vld", out_valid, 1);
    #2 rst = 1'b0;
    #1;
    chk("ar_vld", out_valid, 0);
    chk("ar_core_rst", core_rst, ALL);
    chk("ar_data", out_data, 0);
    chk("ar_ack", core_ack, 0);
    rst = 1'b1;
    #0.5;
    chk("ar_hold_vld", out_valid, 0);
    tick();
    chk("ar_post_rst", core_rst, ALL);
    chk("ar_post_vld", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/core_sched.md
CORE_SCHED -- requirements
Module: core_sched

Interface
REQ-001 SHALL have parameters: N_CORES, default 21, number of processing cores; STAGGER, default 22, cycles between successive core releases (range 1..255); DW, default 28, core result width.
REQ-002 SHALL have port clk  input  1  single clock, all logic rising-edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  one-cycle pulse; begins staggered core release.
REQ-005 SHALL have port abort  input  1  synchronous; returns all cores to reset.
REQ-006 SHALL have port core_rst  output  N_CORES  per-core reset, active-high, one bit per core.
REQ-007 SHALL have port core_valid  input  N_CORES  core i holds a result.
REQ-008 SHALL have port core_data  input  N_CORES*DW  signed results; core i occupies bits [i*DW +: DW].
REQ-009 SHALL have port core_ack  output  N_CORES  one-hot pulse; core i result consumed.
REQ-010 SHALL have port out_valid  output  1  out_data/out_core hold a result.
REQ-011 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-012 SHALL have port out_data  output  DW  selected result.
REQ-013 SHALL have port out_core  output  5  index of the source core.
REQ-014 SHALL have port all_started  output  1  high while in RUN.

Function
REQ-015 SHALL implement FSM IDLE -> STAGGER -> RUN; abort from any state -> IDLE next cycle.
REQ-016 IDLE: start=1 SHALL enter STAGGER with slot=0, cnt=0; start outside IDLE SHALL be ignored.
REQ-017 STAGGER: entry into slot i SHALL clear core_rst[i] on that edge; cores already released stay released.
REQ-018 STAGGER: cnt SHALL count 0..STAGGER-1 per slot; at cnt=STAGGER-1, slot SHALL increment and cnt SHALL clear; after slot N_CORES-1 completes, the FSM SHALL enter RUN.
REQ-019 Core i SHALL be released exactly 1+i*STAGGER cycles after the start edge; RUN SHALL be entered 1+N_CORES*STAGGER cycles after the start edge.
REQ-020 abort SHALL set all core_rst bits to 1, clear out_valid, and zero core_ack in the same cycle it is registered; abort and start together SHALL resolve to abort.
REQ-021 Eligibility: core i SHALL be eligible iff core_valid[i]=1, core_rst[i]=0, and core i was not acked in the previous cycle.
REQ-022 Arbitration SHALL be round-robin: search starts at ptr and wraps from N_CORES-1 to 0; ptr SHALL become winner+1 (mod N_CORES) on each grant.
REQ-023 The output register SHALL load when (out_valid=0 or out_ready=1) and any core is eligible; the load and core_ack[winner]=1 SHALL occur on the same edge.
REQ-024 Latency SHALL be 1 cycle from an eligible core_valid to out_valid.
REQ-025 While out_valid=1 and out_ready=0, out_data and out_core SHALL hold stable and no grant SHALL occur.
REQ-026 If out_valid=1, out_ready=1, and no core is eligible, out_valid SHALL fall next cycle.
REQ-027 Full throughput: with out_ready held high and eligible cores present, one result SHALL be delivered per cycle.
REQ-028 At most one core_ack bit SHALL be high in any cycle.
REQ-029 out_data SHALL be passed bit-exact, with no sign extension or truncation.
REQ-030 Arbitration SHALL run in both STAGGER and RUN, for released cores only.

Reset
REQ-031 rst=0 SHALL asynchronously force: state=IDLE, core_rst all 1, core_ack=0, out_valid=0, out_data=0, out_core=0, ptr=0, cnt=0, slot=0, all_started=0.
REQ-032 rst deassertion SHALL take effect on the first clk edge with rst=1; no output SHALL change before that edge.

Verification
REQ-033 Defaults, start pulse at cycle 0 -> core_rst[0] falls at cycle 1, core_rst[1] at 23, core_rst[20] at 441; all_started rises at 463.
REQ-034 After RUN: core_valid[3], [7], [15] high simultaneously, ptr=0, out_ready=1 -> out_core 3, 7, 15 on consecutive cycles; one-hot ack each cycle; ptr ends at 16.
REQ-035 After RUN: out_ready=0 for 5 cycles with core 2 valid (data 0x8000001) -> out_data holds 0x8000001 and no ack for 5 cycles; single ack when out_ready rises.
REQ-036 Wrap: ptr=20, cores 20 and 0 valid -> grants core 20, then core 0.
REQ-037 abort during STAGGER slot 5, with out_valid=1 -> next cycle core_rst all 1, out_valid=0, state IDLE; a subsequent start restarts from slot 0.
REQ-038 rst pulled low mid-transfer while out_valid=1 -> out_valid=0 and core_rst all 1 immediately, without a clock edge.
